// File: rtl/inst_fetch_decode_pkg.sv
// inst_fetch_decode_pkg
//   Shared RV32I encodings for the fetch/decode front end and the datapath.
//   Holds the opcode values, the instruction-format, ALU-operation and
//   branch-condition encodings, the fetch FSM state type, the decoded bundle
//   struct and a helper that maps funct3/inst[30] to an ALU operation.
package inst_fetch_decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    TYPE_R   = 3'b000,
    TYPE_I   = 3'b001,
    TYPE_S   = 3'b010,
    TYPE_B   = 3'b011,
    TYPE_U   = 3'b100,
    TYPE_J   = 3'b101,
    TYPE_BAD = 3'b111
  } inst_type_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_BLTU = 3'b101,
    BR_BGEU = 3'b110
  } branch_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_OUT  = 2'b11
  } fetch_state_e;

  typedef struct packed {
    logic [6:0]  imm_b_msb;
    logic [4:0]  imm_b_lsb;
    logic [11:0] imm_i;
    logic [19:0] imm_j;
    logic [19:0] imm_u;
    logic [6:0]  imm_s_msb;
    logic [4:0]  imm_s_lsb;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    alu_op_e     alu_ctrl;
    logic        shamt_en;
    branch_e     branch_ctrl;
    logic        jump_ctrl;
    logic        reg_write;
    inst_type_e  inst_type;
    logic        illegal;
  } decode_t;

  // Register-register ops honour inst[30] for SUB; immediate ops only for SRAI
  // (ADDI has no subtract form, inst[30] there is immediate data).
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3,
                                              input logic       alt,
                                              input logic       is_reg);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_decoder.sv
// riscv_decoder
//   Purely combinational RV32I decoder producing the bundle registered by
//   inst_fetch_decode.
//   Ports:
//     inst  in  32          instruction word
//     dec   out decode_t    immediate fields, register indices and controls
module riscv_decoder
  import inst_fetch_decode_pkg::*;
(
  input  logic [31:0] inst,
  output decode_t     dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    dec           = '0;
    // Field slices are emitted for every instruction; the datapath picks the
    // ones relevant to inst_type.
    dec.imm_b_msb = inst[31:25];
    dec.imm_b_lsb = inst[11:7];
    dec.imm_i     = inst[31:20];
    dec.imm_j     = inst[31:12];
    dec.imm_u     = inst[31:12];
    dec.imm_s_msb = inst[31:25];
    dec.imm_s_lsb = inst[11:7];
    dec.rd        = inst[11:7];
    dec.rs1       = inst[19:15];
    dec.rs2       = inst[24:20];
    dec.alu_ctrl    = ALU_ADD;
    dec.branch_ctrl = BR_NONE;
    dec.inst_type   = TYPE_BAD;

    case (opcode)
      OPC_OP: begin
        dec.inst_type = TYPE_R;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_from_funct3(funct3, inst[30], 1'b1);
      end
      OPC_OP_IMM: begin
        dec.inst_type = TYPE_I;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_from_funct3(funct3, inst[30], 1'b0);
        dec.shamt_en  = (funct3 == 3'b001) || (funct3 == 3'b101);
      end
      OPC_LOAD: begin
        dec.inst_type = TYPE_I;
        dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec.inst_type = TYPE_I;
        dec.reg_write = 1'b1;
        dec.jump_ctrl = 1'b1;
      end
      OPC_STORE: begin
        dec.inst_type = TYPE_S;
      end
      OPC_BRANCH: begin
        dec.inst_type = TYPE_B;
        dec.alu_ctrl  = ALU_SUB;
        case (funct3)
          3'b000:  dec.branch_ctrl = BR_BEQ;
          3'b001:  dec.branch_ctrl = BR_BNE;
          3'b100:  dec.branch_ctrl = BR_BLT;
          3'b101:  dec.branch_ctrl = BR_BGE;
          3'b110:  dec.branch_ctrl = BR_BLTU;
          3'b111:  dec.branch_ctrl = BR_BGEU;
          default: dec.illegal     = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.inst_type = TYPE_U;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.inst_type = TYPE_J;
        dec.reg_write = 1'b1;
        dec.jump_ctrl = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_fetch_decode.sv
// inst_fetch_decode
//   Single-outstanding instruction fetch unit with registered decode bundle.
//   Holds the PC, the IDLE/REQ/WAIT/OUT fetch FSM, the kill flag used to drop
//   a response made stale by a redirect, and the output bundle registers.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     imem_req, imem_addr        one-cycle fetch strobe and word address
//     imem_rvalid, imem_rdata    instruction memory response
//     redirect_valid/_pc         taken branch/jump from the datapath
//     out_valid, out_ready       bundle handshake
//     imm_*, rd, rs1, rs2        instruction fields
//     alu_ctrl, shamt_en, branch_ctrl, jump_ctrl, reg_write,
//     inst_type, illegal         decoded controls
module inst_fetch_decode
  import inst_fetch_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  imm_B_MSB,
  output logic [4:0]  imm_B_LSB,
  output logic [11:0] imm_I,
  output logic [19:0] imm_J,
  output logic [19:0] imm_U,
  output logic [6:0]  imm_S_MSB,
  output logic [4:0]  imm_S_LSB,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [3:0]  alu_ctrl,
  output logic        shamt_en,
  output logic [2:0]  branch_ctrl,
  output logic        jump_ctrl,
  output logic        reg_write,
  output logic [2:0]  inst_type,
  output logic        illegal
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  decode_t      bundle_q, bundle_d;
  decode_t      dec;

  riscv_decoder u_riscv_decoder (
    .inst (imem_rdata),
    .dec  (dec)
  );

  // State register: all control and bundle flops clear asynchronously so the
  // outputs go quiet before the next clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      bundle_q <= bundle_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    bundle_d = bundle_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        // The strobe has already gone out this cycle, so its response must
        // be dropped before refetching from the new PC.
        if (redirect_valid) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rvalid) begin
            // Stale response lands with the redirect: nothing left in flight.
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            bundle_d = dec;
            state_d  = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        // Redirect wins over a same-cycle accept; the sequential PC is lost.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    imem_req    = (state_q == ST_REQ);
    imem_addr   = {pc_q[31:2], 2'b00};
    out_valid   = (state_q == ST_OUT);
    imm_B_MSB   = bundle_q.imm_b_msb;
    imm_B_LSB   = bundle_q.imm_b_lsb;
    imm_I       = bundle_q.imm_i;
    imm_J       = bundle_q.imm_j;
    imm_U       = bundle_q.imm_u;
    imm_S_MSB   = bundle_q.imm_s_msb;
    imm_S_LSB   = bundle_q.imm_s_lsb;
    rd          = bundle_q.rd;
    rs1         = bundle_q.rs1;
    rs2         = bundle_q.rs2;
    alu_ctrl    = bundle_q.alu_ctrl;
    shamt_en    = bundle_q.shamt_en;
    branch_ctrl = bundle_q.branch_ctrl;
    jump_ctrl   = bundle_q.jump_ctrl;
    reg_write   = bundle_q.reg_write;
    inst_type   = bundle_q.inst_type;
    illegal     = bundle_q.illegal;
  end

endmodule

// File: tb/tb_inst_fetch_decode.sv
// Bench for inst_fetch_decode: directed scenarios followed by randomized
// fetches, checked against a behavioural model of the fetch/decode rules.
module tb_inst_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        out_valid;
  logic [6:0]  imm_B_MSB, imm_S_MSB;
  logic [4:0]  imm_B_LSB, imm_S_LSB, rd, rs1, rs2;
  logic [11:0] imm_I;
  logic [19:0] imm_J, imm_U;
  logic [3:0]  alu_ctrl;
  logic        shamt_en, jump_ctrl, reg_write, illegal;
  logic [2:0]  branch_ctrl, inst_type;

  // Second instance, reset PC at the top of the address space.
  logic        hi_req, hi_out_valid;
  logic [31:0] hi_addr;
  logic [6:0]  hi_b_msb, hi_s_msb;
  logic [4:0]  hi_b_lsb, hi_s_lsb, hi_rd, hi_rs1, hi_rs2;
  logic [11:0] hi_imm_i;
  logic [19:0] hi_imm_j, hi_imm_u;
  logic [3:0]  hi_alu;
  logic        hi_shamt, hi_jump, hi_rw, hi_illegal;
  logic [2:0]  hi_branch, hi_type;

  inst_fetch_decode #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm_B_MSB(imm_B_MSB), .imm_B_LSB(imm_B_LSB), .imm_I(imm_I),
    .imm_J(imm_J), .imm_U(imm_U), .imm_S_MSB(imm_S_MSB), .imm_S_LSB(imm_S_LSB),
    .rd(rd), .rs1(rs1), .rs2(rs2), .alu_ctrl(alu_ctrl), .shamt_en(shamt_en),
    .branch_ctrl(branch_ctrl), .jump_ctrl(jump_ctrl), .reg_write(reg_write),
    .inst_type(inst_type), .illegal(illegal)
  );

  inst_fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .rst_n(rst_n),
    .imem_req(hi_req), .imem_addr(hi_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(hi_out_valid), .out_ready(out_ready),
    .imm_B_MSB(hi_b_msb), .imm_B_LSB(hi_b_lsb), .imm_I(hi_imm_i),
    .imm_J(hi_imm_j), .imm_U(hi_imm_u), .imm_S_MSB(hi_s_msb), .imm_S_LSB(hi_s_lsb),
    .rd(hi_rd), .rs1(hi_rs1), .rs2(hi_rs2), .alu_ctrl(hi_alu), .shamt_en(hi_shamt),
    .branch_ctrl(hi_branch), .jump_ctrl(hi_jump), .reg_write(hi_rw),
    .inst_type(hi_type), .illegal(hi_illegal)
  );

  logic [104:0] obs_bundle;
  assign obs_bundle = {imm_B_MSB, imm_B_LSB, imm_I, imm_J, imm_U, imm_S_MSB, imm_S_LSB,
                       rd, rs1, rs2, alu_ctrl, shamt_en, branch_ctrl, jump_ctrl,
                       reg_write, inst_type, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_hi;
  bit          hi_track;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: expected bundle from the instruction-set tables.
  function automatic logic [104:0] model(input logic [31:0] i);
    int alu_by_f3 [8] = '{0, 5, 8, 9, 4, 6, 3, 2};   // ADD SLL SLT SLTU XOR SRL OR AND
    int br_by_f3  [8] = '{1, 2, 0, 0, 3, 4, 5, 6};   // BEQ BNE - - BLT BGE BLTU BGEU
    int f3, alu, br, typ;
    bit alt, sh, jmp, rw, ill;
    f3 = int'(i[14:12]);
    alt = i[30];
    alu = 0; br = 0; typ = 7; sh = 0; jmp = 0; rw = 0; ill = 0;
    case (i[6:0])
      7'h33: begin
        typ = 0; rw = 1; alu = alu_by_f3[f3];
        if (alt && f3 == 0) alu = 1;
        if (alt && f3 == 5) alu = 7;
      end
      7'h13: begin
        typ = 1; rw = 1; alu = alu_by_f3[f3];
        if (alt && f3 == 5) alu = 7;
        sh = (f3 == 1) || (f3 == 5);
      end
      7'h03: begin typ = 1; rw = 1; end
      7'h67: begin typ = 1; rw = 1; jmp = 1; end
      7'h23: typ = 2;
      7'h63: begin
        typ = 3; alu = 1; br = br_by_f3[f3];
        ill = (f3 == 2) || (f3 == 3);
      end
      7'h37, 7'h17: begin typ = 4; rw = 1; end
      7'h6f: begin typ = 5; rw = 1; jmp = 1; end
      default: ill = 1;
    endcase
    return {i[31:25], i[11:7], i[31:20], i[31:12], i[31:12], i[31:25], i[11:7],
            i[11:7], i[19:15], i[24:20], alu[3:0], sh, br[2:0], jmp, rw, typ[2:0], ill};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h7f};
    logic [31:0] r;
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    r[1:0] = 2'b00;
    return r;
  endfunction

  // Waits (bounded) for the fetch strobe and checks the address.
  task automatic wait_req();
    bit ok;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (imem_req) begin ok = 1; break; end
      tick();
    end
    chk("req_seen", ok, 1'b1);
    chk("imem_addr", imem_addr, exp_pc);
    if (hi_track) chk("hi_imem_addr", hi_addr, exp_hi);
  endtask

  // Fetch with response latency lat; returns with the bundle presented.
  task automatic fetch_to_out(input logic [31:0] inst, input int lat);
    wait_req();
    tick();
    chk("req_one_cycle", imem_req, 1'b0);
    repeat (lat - 1) begin
      chk("no_valid_in_wait", out_valid, 1'b0);
      tick();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = inst;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("out_valid", out_valid, 1'b1);
    chk("bundle", obs_bundle, model(inst));
  endtask

  // Holds out_ready low for n cycles with stray responses that must be ignored.
  task automatic hold(input logic [31:0] inst, input int n);
    for (int k = 0; k < n; k++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      tick();
      imem_rvalid = 1'b0;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_bundle", obs_bundle, model(inst));
      chk("hold_no_req", imem_req, 1'b0);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_pc = exp_pc + 32'd4;
    exp_hi = exp_hi + 32'd4;
    chk("drop_after_accept", out_valid, 1'b0);
  endtask

  // Redirect at a random point of WAIT, possibly coinciding with the response.
  task automatic redirect_in_wait(input int lat, input logic [31:0] np);
    int r;
    r = $urandom_range(0, lat - 1);
    wait_req();
    tick();
    for (int k = 1; k <= lat; k++) begin
      if (k == 1 + r) begin redirect_valid = 1'b1; redirect_pc = np; end
      if (k == lat)   begin imem_rvalid = 1'b1; imem_rdata = rand_inst(); end
      tick();
      redirect_valid = 1'b0;
      imem_rvalid    = 1'b0;
      chk("stale_no_valid", out_valid, 1'b0);
    end
    exp_pc   = np;
    hi_track = 0;
    chk("refetch_req", imem_req, 1'b1);
    chk("refetch_addr", imem_addr, np);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] inst;
    logic [31:0] np;
    int mode;

    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    exp_pc = 32'h0; exp_hi = 32'hFFFF_FFFC; hi_track = 1;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_bundle", obs_bundle, 105'd0);
    chk("rst_pc", imem_addr, 32'h0);
    chk("rst_pc_hi", hi_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // add x2,x1,x2 at latency 1, immediate accept
    fetch_to_out(32'h0020_8133, 1);
    chk("add_rd", rd, 5'd2);
    chk("add_rs1", rs1, 5'd1);
    chk("add_rs2", rs2, 5'd2);
    chk("add_alu", alu_ctrl, 4'b0000);
    chk("add_type", inst_type, 3'b000);
    chk("add_rw", reg_write, 1'b1);
    accept();

    // srai held for 5 cycles; hi instance wraps FFFFFFFC -> 0 here
    fetch_to_out(32'h4041_5093, 2);
    chk("srai_alu", alu_ctrl, 4'b0111);
    chk("srai_shamt", shamt_en, 1'b1);
    hold(32'h4041_5093, 5);
    accept();

    // unsupported opcode still presented, flagged illegal
    fetch_to_out(32'hFFFF_FFFF, 1);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_rw", reg_write, 1'b0);
    accept();

    // redirect during WAIT, stale response 3 cycles after the request
    wait_req();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    exp_pc = 32'h100; hi_track = 0;
    chk("kill_wait_valid", out_valid, 1'b0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_8133;
    tick();
    imem_rvalid = 1'b0;
    chk("kill_drop_valid", out_valid, 1'b0);
    chk("kill_req", imem_req, 1'b1);
    chk("kill_addr", imem_addr, 32'h100);

    // beq, then redirect and handshake in the same cycle
    fetch_to_out(32'h0020_8463, 1);
    chk("beq_type", inst_type, 3'b011);
    chk("beq_br", branch_ctrl, 3'b001);
    chk("beq_alu", alu_ctrl, 4'b0001);
    chk("beq_rw", reg_write, 1'b0);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    out_ready = 1'b0; redirect_valid = 1'b0;
    exp_pc = 32'h200;
    chk("redir_prio_valid", out_valid, 1'b0);
    chk("redir_prio_req", imem_req, 1'b1);
    chk("redir_prio_addr", imem_addr, 32'h200);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      mode = $urandom_range(0, 5);
      inst = rand_inst();
      if (mode == 0) begin
        redirect_in_wait($urandom_range(1, 4), rand_pc());
      end else begin
        fetch_to_out(inst, $urandom_range(1, 4));
        hold(inst, $urandom_range(0, 3));
        if (mode == 1) begin
          np = rand_pc();
          out_ready = 1'($urandom_range(0, 1));
          redirect_valid = 1'b1; redirect_pc = np;
          tick();
          out_ready = 1'b0; redirect_valid = 1'b0;
          exp_pc = np; hi_track = 0;
          chk("rand_redir_valid", out_valid, 1'b0);
        end else begin
          accept();
        end
      end
    end

    // asynchronous reset while the bundle is presented
    fetch_to_out(32'h0000_0513, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_imem_req", imem_req, 1'b0);
    chk("async_bundle", obs_bundle, 105'd0);
    chk("async_pc", imem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    exp_pc = 32'h0; exp_hi = 32'hFFFF_FFFC; hi_track = 1;
    // a stray response while IDLE must not produce a bundle
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_8133;
    tick();
    imem_rvalid = 1'b0;
    chk("idle_stray_valid", out_valid, 1'b0);
    fetch_to_out(32'h0010_00EF, 2);
    accept();
    wait_req();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
